// File: rtl/simd_mask_reducer.sv
// Reduces a per-lane comparator mask to a packed lane bitmap plus count/any/all/first-index
// summaries, through a two-stage valid/ready pipeline with a saturating any-hit event counter.
module simd_mask_reducer #(
  parameter int SIMD_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIMD_WIDTH-1:0] mask,
  input  logic [2:0]            data_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           packed_mask,
  output logic [5:0]            lane_count,
  output logic                  any,
  output logic                  all,
  output logic [4:0]            first_idx,
  input  logic                  evt_clr,
  output logic [15:0]           evt_count
);

  localparam int LANE8 = SIMD_WIDTH / 32;

  logic        s1_valid;
  logic [31:0] s1_msb;
  logic [2:0]  s1_mode;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] mask_msb;
  logic [31:0] packed_c;
  logic [5:0]  n_lanes_c;
  logic [5:0]  count_c;
  logic [4:0]  first_c;
  logic        unused_mask;

  // Every wider lane's MSB is also the MSB of some 8-bit lane, so only those 32 bits are kept.
  always_comb begin
    mask_msb = '0;
    for (int i = 0; i < 32; i++) begin
      mask_msb[i] = mask[i*LANE8 + LANE8 - 1];
    end
  end

  assign unused_mask = ^mask;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_msb   <= '0;
      s1_mode  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_msb  <= mask_msb;
        s1_mode <= data_mode;
      end
    end
  end

  always_comb begin
    packed_c  = '0;
    n_lanes_c = 6'd1;
    case (s1_mode)
      3'd0: begin
        n_lanes_c = 6'd32;
        packed_c  = s1_msb;
      end
      3'd1: begin
        n_lanes_c = 6'd16;
        for (int i = 0; i < 16; i++) packed_c[i] = s1_msb[2*i + 1];
      end
      3'd2: begin
        n_lanes_c = 6'd8;
        for (int i = 0; i < 8; i++) packed_c[i] = s1_msb[4*i + 3];
      end
      3'd3: begin
        n_lanes_c = 6'd4;
        for (int i = 0; i < 4; i++) packed_c[i] = s1_msb[8*i + 7];
      end
      3'd4: begin
        n_lanes_c = 6'd2;
        for (int i = 0; i < 2; i++) packed_c[i] = s1_msb[16*i + 15];
      end
      default: begin
        n_lanes_c   = 6'd1;
        packed_c[0] = s1_msb[31];
      end
    endcase
  end

  always_comb begin
    count_c = '0;
    for (int i = 0; i < 32; i++) begin
      count_c = count_c + 6'(packed_c[i]);
    end
  end

  // Downward scan so the lowest set lane is the last one written.
  always_comb begin
    first_c = '0;
    for (int i = 31; i >= 0; i--) begin
      if (packed_c[i]) first_c = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      packed_mask <= '0;
      lane_count  <= '0;
      any         <= 1'b0;
      all         <= 1'b0;
      first_idx   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        packed_mask <= packed_c;
        lane_count  <= count_c;
        any         <= (count_c != 6'd0);
        all         <= (count_c == n_lanes_c);
        first_idx   <= first_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || evt_clr) begin
      evt_count <= '0;
    end else if (out_valid && out_ready && any && (evt_count != 16'hFFFF)) begin
      evt_count <= evt_count + 16'd1;
    end
  end

endmodule

// File: doc/simd_mask_reducer.md
SIMD_MASK_REDUCER -- requirements
Module: simd_mask_reducer

Interface
REQ-001 Parameter SIMD_WIDTH, default 256, operand and mask width in bits; only 256 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  mask beat present.
REQ-005 in_ready  output  1  block accepts beat this cycle.
REQ-006 mask  input  256  lane mask from comparator stage (each lane all-ones or all-zeros).
REQ-007 data_mode  input  3  lane width select: 0=8b, 1=16b, 2=32b, 3=64b, 4=128b, 5..7=256b.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 packed  output  32  one bit per lane, lane 0 at bit 0.
REQ-011 lane_count  output  6  number of set lanes, 0..32.
REQ-012 any  output  1  at least one lane set.
REQ-013 all  output  1  every active lane set.
REQ-014 first_idx  output  5  index of the lowest set lane; 0 when none is set.
REQ-015 evt_clr  input  1  clears event counter.
REQ-016 evt_count  output  16  saturating count of delivered results with any=1.

Function
REQ-017 Lane count N shall be 32, 16, 8, 4, 2 or 1 for data_mode 0, 1, 2, 3, 4 or 5..7 respectively.
REQ-018 packed[i] for i<N shall equal mask bit (i+1)*(256/N)-1, which is the lane MSB; packed[i] for i>=N shall be 0.
REQ-019 Mask bits other than lane MSBs shall be ignored; non-uniform lanes are not flagged.
REQ-020 lane_count shall be the popcount of packed.
REQ-021 any shall be 1 when lane_count is nonzero.
REQ-022 all shall be 1 when lane_count equals N.
REQ-023 first_idx shall be the position of the least significant 1 in packed, or 0 when packed is 0.
REQ-024 The block shall be a two-stage pipeline: S1 registers mask and data_mode; S2 registers all reduced outputs.
REQ-025 A beat is accepted when in_valid and in_ready are both 1.
REQ-026 Its result shall appear with out_valid=1 exactly 2 cycles later when out_ready is held at 1.
REQ-027 A result is delivered when out_valid and out_ready are both 1.
REQ-028 Each stage shall advance when it is empty or when its downstream stage advances in the same cycle.
REQ-029 in_ready shall equal the S1 advance condition, is combinational, and shall not depend on in_valid.
REQ-030 Sustained throughput shall be one beat per cycle while out_ready=1.
REQ-031 While out_valid=1 and out_ready=0, the outputs packed, lane_count, any, all and first_idx shall hold stable.
REQ-032 While out_valid=1 and out_ready=0, out_valid shall remain 1.
REQ-033 When both stages are full and out_ready=0, in_ready shall be 0 and no beat shall be lost or duplicated.
REQ-034 data_mode shall be captured with its mask; a mode change between beats shall affect only later beats.
REQ-035 evt_count shall increment by 1 on each delivered result with any=1.
REQ-036 evt_count shall saturate at 0xFFFF.
REQ-037 evt_clr=1 shall set evt_count to 0 on the next edge; clear wins over a simultaneous increment.
REQ-038 When out_valid=0, data outputs shall hold their last value, and the consumer ignores them.

Reset
REQ-039 With rst=1 at an edge, out_valid and the internal S1 valid shall be 0.
REQ-040 With rst=1 at an edge, packed, lane_count, any, all, first_idx and evt_count shall be 0.
REQ-041 During reset, in_ready shall be 0.
REQ-042 Reset mid-operation shall discard in-flight beats; none shall be delivered after reset.
REQ-043 in_ready shall return to 1 in the first cycle after rst deasserts.

Verification
REQ-044 Mode 0, mask with bytes 0, 3 and 31 all-ones, out_ready=1 -> 2 cycles later: packed=0x80000009, lane_count=3, any=1, all=0, first_idx=0.
REQ-045 Mode 2, mask all-ones -> packed=0x000000FF, lane_count=8, all=1.
REQ-046 Mode 6, mask all-ones -> packed=0x00000001, lane_count=1, all=1.
REQ-047 Mode 1, mask all-zeros -> packed=0, lane_count=0, any=0, all=0, first_idx=0, evt_count unchanged.
REQ-048 Back-to-back beats A,B,C with out_ready=0 for 3 cycles -> in_ready=0 while both stages are full, A held stable, then A,B,C delivered in order, each exactly once.
REQ-049 Drive 65537 delivered results with any=1 -> evt_count=0xFFFF.
REQ-050 Apply evt_clr in the same cycle as a delivery with any=1 -> evt_count=0.
REQ-051 Assert rst with two beats in flight -> out_valid=0 and evt_count=0 next cycle, no stale result delivered afterwards.
